// File: rtl/serial_arith_defs_pkg.sv
// Shared definitions for the serial arithmetic datapaths: FSM state
// encodings and the default operand width.
package serial_arith_defs;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subbit_sub_subbit.sv
// One-bit full-subtractor cell, gate-level twin of the 1-bit adder cell.
module subbit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic t, na, nt, p, q;

    xor g_x1 (t, a, b);
    xor g_x2 (d, t, bi);
    not g_n1 (na, a);
    and g_a1 (p, na, b);
    not g_n2 (nt, t);
    and g_a2 (q, nt, bi);
    or  g_o1 (bo, p, q);

endmodule

// File: rtl/serial_subbit_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock, with start/done handshake and registered result flags.
module serial_subbit_sub
    import serial_arith_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, res;
    logic [CNT_W-1:0] cnt;
    logic             br, a_msb, b_msb;
    logic             d, bo;
    logic             last, accept;

    subbit u_cell (
        .a  (sa[0]),
        .b  (sb[0]),
        .bi (br),
        .d  (d),
        .bo (bo)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Working result register is separate from diff so the published result
    // stays stable while the next operation runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            res <= {d, res[WIDTH-1:1]};
            br  <= bo;
            cnt <= cnt + 1'b1;
            if (last) begin
                diff       <= {d, res[WIDTH-1:1]};
                borrow_out <= bo;
                ovf        <= (a_msb ^ b_msb) & (a_msb ^ d);
            end
        end
    end

endmodule
